// File: rtl/mem_write_checker.sv
// mem_write_checker
// Self-check monitor for a data-memory write port. It snoops MemWrite/Adr/
// WriteData and compares every write against a programmed, ordered table of
// expected (address, data) pairs. The result is either PASS, or FAIL with a
// reason code and the captured offending write. It also fails when no write
// is accepted for TIMEOUT_CYC cycles.
//
// Build option: define MWC_IGNORE_EN to skip writes that fall in the
// scratch/stack window (Adr & IGN_MASK) == IGN_BASE. Without it, every
// RUN-state write is checked against the table.
//
// Handshake: there is no valid/ready pair. cfg_we is a one-cycle write strobe.
// start is a one-cycle pulse. MemWrite qualifies Adr/WriteData on each rising
// edge. Outputs are registered and reflect the write sampled on the previous
// edge.
//
// FSM state is visible on dbg_state: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL.
module mem_write_checker #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_EXP     = 4,
  parameter int                TIMEOUT_CYC = 1024,
  parameter logic [ADDR_W-1:0] IGN_BASE    = ADDR_W'(96),
  parameter logic [ADDR_W-1:0] IGN_MASK    = ADDR_W'(32'hFFFF_FFFC),
  localparam int               IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int               CNT_W       = $clog2(NUM_EXP + 1),
  localparam int               TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_adr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_DATA = 2'd1;
  localparam logic [1:0] CODE_ADR  = 2'd2;
  localparam logic [1:0] CODE_TMO  = 2'd3;

`ifdef MWC_IGNORE_EN
  localparam bit IGN_EN = 1'b1;
`else
  localparam bit IGN_EN = 1'b0;
`endif

  localparam logic [IDX_W:0]   NUM_L    = (IDX_W + 1)'(NUM_EXP);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_EXP - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] tbl_adr  [NUM_EXP];
  logic [DATA_W-1:0] tbl_data [NUM_EXP];
  logic [TMR_W-1:0]  timer;

  logic [IDX_W-1:0]  ptr_idx;
  logic [ADDR_W-1:0] exp_adr;
  logic [DATA_W-1:0] exp_data;
  logic              idx_ok;
  logic              adr_hit;
  logic              data_hit;
  logic              in_ign;
  logic              is_last;
  logic              timer_exp;

  logic              accept;
  logic              load_fail;
  logic [1:0]        code_nxt;
  logic [ADDR_W-1:0] fadr_nxt;
  logic [DATA_W-1:0] fdata_nxt;

  // The accepted-write count doubles as the table pointer.
  assign ptr_idx   = match_cnt[IDX_W-1:0];
  assign exp_adr   = tbl_adr[ptr_idx];
  assign exp_data  = tbl_data[ptr_idx];
  assign idx_ok    = ({1'b0, cfg_idx} < NUM_L);
  assign adr_hit   = MemWrite && (Adr == exp_adr);
  assign data_hit  = (WriteData == exp_data);
  assign in_ign    = IGN_EN && ((Adr & IGN_MASK) == IGN_BASE);
  assign is_last   = (match_cnt == LAST_CNT);
  assign timer_exp = (timer == TMR_LAST);

  assign done      = (state == S_PASS) || (state == S_FAIL);
  assign pass      = (state == S_PASS);
  assign dbg_state = state;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle events. The table match is checked before
  // the ignore window, and an accepted write is checked before the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_fail = 1'b0;
    code_nxt  = CODE_NONE;
    fadr_nxt  = '0;
    fdata_nxt = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (adr_hit && data_hit) begin
          accept = 1'b1;
          if (is_last) state_nxt = S_PASS;
        end else if (adr_hit) begin
          state_nxt = S_FAIL;
          load_fail = 1'b1;
          code_nxt  = CODE_DATA;
          fadr_nxt  = Adr;
          fdata_nxt = WriteData;
        end else if (MemWrite && !in_ign) begin
          state_nxt = S_FAIL;
          load_fail = 1'b1;
          code_nxt  = CODE_ADR;
          fadr_nxt  = Adr;
          fdata_nxt = WriteData;
        end else if (timer_exp) begin
          state_nxt = S_FAIL;
          load_fail = 1'b1;
          code_nxt  = CODE_TMO;
        end
      end
      S_PASS:  state_nxt = S_PASS;
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Expected-write table, writable only while idle. Out-of-range indices are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        tbl_adr[i]  <= '0;
        tbl_data[i] <= '0;
      end
    end else if ((state == S_IDLE) && cfg_we && idx_ok) begin
      tbl_adr[cfg_idx]  <= cfg_adr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  // Accepted-write counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         match_cnt <= '0;
    else if ((state == S_IDLE) && start) match_cnt <= '0;
    else if (accept)                    match_cnt <= match_cnt + 1'b1;
  end

  // Progress timer. It restarts on start or on an accepted write and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if ((state == S_IDLE) && start) begin
      timer <= '0;
    end else if (state == S_RUN) begin
      if (accept)                timer <= '0;
      else if (timer != TMR_MAX) timer <= timer + 1'b1;
    end
  end

  // Failure capture, loaded only on the transition into FAIL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_code <= CODE_NONE;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (load_fail) begin
      fail_code <= code_nxt;
      fail_adr  <= fadr_nxt;
      fail_data <= fdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker. Two instances share one stimulus stream.
// u1 has NUM_EXP=1 and u4 has NUM_EXP=4, and both use TIMEOUT_CYC=16.
// A table-level model predicts every output of both instances. It is checked
// on each falling edge, and literal expectations at key points pin the model.
module tb_mem_write_checker;

`ifdef MWC_IGNORE_EN
  localparam bit IGN_ON = 1'b1;
`else
  localparam bit IGN_ON = 1'b0;
`endif
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [0:0]  cfg_idx1 = '0;
  logic [31:0] cfg_adr = '0;
  logic [31:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;

  logic        u1_done, u1_pass, u4_done, u4_pass;
  logic [1:0]  u1_code, u4_code, u1_st, u4_st;
  logic [0:0]  u1_cnt;
  logic [2:0]  u4_cnt;
  logic [31:0] u1_fa, u1_fd, u4_fa, u4_fd;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, index 0 -> u1, index 1 -> u4
  logic [31:0] m_ta [2][4];
  logic [31:0] m_td [2][4];
  int          m_cnt [2];
  int          m_quiet [2];
  bit          m_run [2];
  bit          m_done [2];
  bit          m_pass [2];
  logic [1:0]  m_code [2];
  logic [31:0] m_fa [2];
  logic [31:0] m_fd [2];

  mem_write_checker #(.NUM_EXP(1), .TIMEOUT_CYC(TMO)) u1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx1),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .start(start),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .done(u1_done), .pass(u1_pass), .fail_code(u1_code), .match_cnt(u1_cnt),
    .fail_adr(u1_fa), .fail_data(u1_fd), .dbg_state(u1_st)
  );

  mem_write_checker #(.NUM_EXP(4), .TIMEOUT_CYC(TMO)) u4 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .start(start),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .done(u4_done), .pass(u4_pass), .fail_code(u4_code), .match_cnt(u4_cnt),
    .fail_adr(u4_fa), .fail_data(u4_fd), .dbg_state(u4_st)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic m_fail(input int k, input logic [1:0] code, input logic [31:0] a, input logic [31:0] d);
    m_run[k]  <= 1'b0;
    m_done[k] <= 1'b1;
    m_code[k] <= code;
    m_fa[k]   <= a;
    m_fd[k]   <= d;
  endtask

  task automatic model_step(input int k);
    int          n;
    logic [1:0]  idx;
    logic [31:0] ea, ed;
    bit          ign;
    n   = (k == 0) ? 1 : 4;
    idx = (k == 0) ? {1'b0, cfg_idx1} : cfg_idx;
    ign = IGN_ON && ((Adr & 32'hFFFF_FFFC) == 32'd96);
    if (!m_run[k] && !m_done[k]) begin
      if (cfg_we && (int'(idx) < n)) begin
        m_ta[k][idx] <= cfg_adr;
        m_td[k][idx] <= cfg_data;
      end
      if (start) begin
        m_run[k]   <= 1'b1;
        m_cnt[k]   <= 0;
        m_quiet[k] <= 0;
      end
    end else if (m_run[k]) begin
      ea = m_ta[k][m_cnt[k]];
      ed = m_td[k][m_cnt[k]];
      if (MemWrite && Adr == ea && WriteData == ed) begin
        m_cnt[k]   <= m_cnt[k] + 1;
        m_quiet[k] <= 0;
        if (m_cnt[k] + 1 == n) begin
          m_run[k]  <= 1'b0;
          m_done[k] <= 1'b1;
          m_pass[k] <= 1'b1;
        end
      end else if (MemWrite && Adr == ea) begin
        m_fail(k, 2'd1, Adr, WriteData);
      end else if (MemWrite && !ign) begin
        m_fail(k, 2'd2, Adr, WriteData);
      end else if (m_quiet[k] + 1 == TMO) begin
        m_fail(k, 2'd3, 32'd0, 32'd0);
      end else begin
        m_quiet[k] <= m_quiet[k] + 1;
      end
    end
  endtask

  // model update: async clear, otherwise one step per rising edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          m_ta[k][i] <= '0;
          m_td[k][i] <= '0;
        end
        m_cnt[k] <= 0; m_quiet[k] <= 0; m_run[k] <= 1'b0;
        m_done[k] <= 1'b0; m_pass[k] <= 1'b0; m_code[k] <= '0;
        m_fa[k] <= '0; m_fd[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // compare process: every falling edge, both instances against the model
  always @(negedge clk) begin
    chk("u1_done", 32'(u1_done), 32'(m_done[0]));
    chk("u1_pass", 32'(u1_pass), 32'(m_pass[0]));
    chk("u1_code", 32'(u1_code), 32'(m_code[0]));
    chk("u1_cnt",  32'(u1_cnt),  32'(m_cnt[0]));
    chk("u1_fadr", u1_fa, m_fa[0]);
    chk("u1_fdat", u1_fd, m_fd[0]);
    chk("u4_done", 32'(u4_done), 32'(m_done[1]));
    chk("u4_pass", 32'(u4_pass), 32'(m_pass[1]));
    chk("u4_code", 32'(u4_code), 32'(m_code[1]));
    chk("u4_cnt",  32'(u4_cnt),  32'(m_cnt[1]));
    chk("u4_fadr", u4_fa, m_fa[1]);
    chk("u4_fdat", u4_fd, m_fd[1]);
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d, input bit st);
    cfg_we = 1'b1; cfg_idx = idx; cfg_idx1 = (idx == 2'd0) ? 1'b0 : 1'b1;
    cfg_adr = a; cfg_data = d; start = st;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic prog_and_start();
    cfg(2'd0, 32'd100, 32'd7, 1'b0);
    cfg(2'd1, 32'd104, 32'd8, 1'b0);
    cfg(2'd2, 32'd108, 32'd9, 1'b0);
    cfg(2'd3, 32'd112, 32'd10, 1'b1);
  endtask

  task automatic start_only();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_done", 32'(u4_done), 32'd0);
    chk("rst_code", 32'(u4_code), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // A: idle write ignored, then ignore-window write, then full sequence
    wr(32'd100, 32'd7);
    chk("A_idle_cnt", 32'(u4_cnt), 32'd0);
    prog_and_start();
    wr(32'd96, 32'd3);
    chk("A_ign_done", 32'(u1_done), IGN_ON ? 32'd0 : 32'd1);
    wr(32'd100, 32'd7);
    chk("A_u1_pass", 32'(u1_pass), IGN_ON ? 32'd1 : 32'd0);
    chk("A_u1_cnt",  32'(u1_cnt),  IGN_ON ? 32'd1 : 32'd0);
    chk("A_u1_code", 32'(u1_code), IGN_ON ? 32'd0 : 32'd2);
    chk("A_u1_fadr", u1_fa, IGN_ON ? 32'd0 : 32'd96);
    wr(32'd104, 32'd8);
    wr(32'd108, 32'd9);
    wr(32'd112, 32'd10);
    chk("A_u4_pass", 32'(u4_pass), IGN_ON ? 32'd1 : 32'd0);
    chk("A_u4_cnt",  32'(u4_cnt),  IGN_ON ? 32'd4 : 32'd0);
    // sticky verdict: further activity is ignored
    start_only();
    wr(32'd5, 32'd5);
    chk("A_sticky", 32'(u4_code), IGN_ON ? 32'd0 : 32'd2);

    // B: data mismatch
    do_reset();
    prog_and_start();
    wr(32'd100, 32'd8);
    chk("B_done", 32'(u1_done), 32'd1);
    chk("B_code", 32'(u1_code), 32'd1);
    chk("B_fadr", u1_fa, 32'd100);
    chk("B_fdat", u1_fd, 32'd8);

    // C: address mismatch
    do_reset();
    prog_and_start();
    wr(32'd80, 32'd7);
    chk("C_code", 32'(u4_code), 32'd2);
    chk("C_fadr", u4_fa, 32'd80);

    // D: timeout exactly TMO cycles after the start edge
    do_reset();
    prog_and_start();
    idle(TMO - 1);
    chk("D_early", 32'(u1_done), 32'd0);
    idle(1);
    chk("D_done", 32'(u1_done), 32'd1);
    chk("D_code", 32'(u1_code), 32'd3);
    chk("D_fadr", u1_fa, 32'd0);

    // E: final match on the timeout edge wins
    do_reset();
    prog_and_start();
    idle(TMO - 1);
    wr(32'd100, 32'd7);
    chk("E_pass", 32'(u1_pass), 32'd1);
    chk("E_code", 32'(u1_code), 32'd0);
    chk("E_u4cnt", 32'(u4_cnt), 32'd1);
    chk("E_u4done", 32'(u4_done), 32'd0);

    // F: order swapped at index 2
    do_reset();
    prog_and_start();
    wr(32'd100, 32'd7);
    wr(32'd104, 32'd8);
    wr(32'd112, 32'd10);
    chk("F_code", 32'(u4_code), 32'd2);
    chk("F_cnt",  32'(u4_cnt),  32'd2);
    chk("F_fadr", u4_fa, 32'd112);

    // G: asynchronous reset mid-RUN, restart with the cleared table
    do_reset();
    prog_and_start();
    wr(32'd100, 32'd7);
    chk("G_pre_cnt", 32'(u4_cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("G_async_cnt",  32'(u4_cnt),  32'd0);
    chk("G_async_done", 32'(u1_done), 32'd0);
    chk("G_async_pass", 32'(u1_pass), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_only();
    wr(32'd100, 32'd7);
    chk("G_code", 32'(u4_code), 32'd2);
    chk("G_fadr", u4_fa, 32'd100);
    chk("G_u1code", 32'(u1_code), 32'd2);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
